// File: rtl/matrix_txpiectrl.sv
// TX frame sequencer ahead of the PIE encoder: sends a preamble or frame-sync
// header, then shifts command bits MSB-first through the data-symbol handshake.
module matrix_txpiectrl #(
  parameter int                DATA_W   = 64,
  parameter int                CNT_W    = 7,
  parameter int                WDOG_W   = 20,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 20'hFFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              tx_Start,
  input  logic              tx_Abort,
  input  logic              tx_UsePreamble,
  input  logic [CNT_W-1:0]  tx_BitCount,
  input  logic [DATA_W-1:0] tx_Data,
  output logic              p_PreambleLoad,
  output logic              p_PreambleStart,
  input  logic              p_PreambleDone,
  output logic              p_FrameSyncLoad,
  output logic              p_FrameSyncStart,
  input  logic              p_FrameSyncDone,
  output logic              tx_LoadPIE,
  output logic              tx_StartPIE,
  output logic              tx_ShiftOut,
  input  logic              tx_ShiftNextBitToPIE,
  output logic              tx_Busy,
  output logic              tx_Done,
  output logic              tx_Error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LOAD, S_HDR_RUN, S_BIT_LOAD, S_BIT_RUN, S_FINISH
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_sreg;
  logic                r_hdr_pre;
  logic [CNT_W-1:0]    r_bits_left;
  logic [WDOG_W-1:0]   r_wdog;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_sreg_nxt;
  logic                w_hdr_pre_nxt;
  logic [CNT_W-1:0]    w_bits_nxt;
  logic [CNT_W-1:0]    w_bits_dec;
  logic [CNT_W-1:0]    w_bits_clamp;
  logic [WDOG_W-1:0]   w_wdog_nxt;
  logic [WDOG_W-1:0]   w_wdog_inc;
  logic                w_wdog_exp;
  logic                w_hdr_done;
  logic                w_err_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_hdr_pre_nxt = r_hdr_pre;
    w_bits_nxt    = r_bits_left;
    w_wdog_nxt    = r_wdog;
    w_err_nxt     = 1'b0;
    w_wdog_inc    = r_wdog + WDOG_W'(1);
    w_wdog_exp    = (w_wdog_inc == WDOG_MAX);
    w_hdr_done    = r_hdr_pre ? p_PreambleDone : p_FrameSyncDone;
    w_bits_dec    = r_bits_left - CNT_W'(1);
    w_bits_clamp  = (tx_BitCount > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : tx_BitCount;

    // Abort overrides every transition and leaves the shift register untouched
    if (tx_Abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (tx_Start) begin
            w_sreg_nxt    = tx_Data;
            w_hdr_pre_nxt = tx_UsePreamble;
            w_bits_nxt    = w_bits_clamp;
            w_state_nxt   = S_HDR_LOAD;
          end
        end
        S_HDR_LOAD: begin
          w_wdog_nxt  = '0;
          w_state_nxt = S_HDR_RUN;
        end
        S_HDR_RUN: begin
          w_wdog_nxt = w_wdog_inc;
          if (w_hdr_done) begin
            w_state_nxt = (r_bits_left == '0) ? S_FINISH : S_BIT_LOAD;
          end else if (w_wdog_exp) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
        S_BIT_LOAD: begin
          w_wdog_nxt  = '0;
          w_state_nxt = S_BIT_RUN;
        end
        S_BIT_RUN: begin
          w_wdog_nxt = w_wdog_inc;
          if (tx_ShiftNextBitToPIE) begin
            w_sreg_nxt  = {r_sreg[DATA_W-2:0], 1'b0};
            w_bits_nxt  = w_bits_dec;
            w_state_nxt = (w_bits_dec == '0) ? S_FINISH : S_BIT_LOAD;
          end else if (w_wdog_exp) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state and outputs: outputs are decoded from the next state so they are registered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state          <= S_IDLE;
      r_hdr_pre        <= 1'b0;
      r_bits_left      <= '0;
      r_wdog           <= '0;
      p_PreambleLoad   <= 1'b0;
      p_PreambleStart  <= 1'b0;
      p_FrameSyncLoad  <= 1'b0;
      p_FrameSyncStart <= 1'b0;
      tx_LoadPIE       <= 1'b0;
      tx_StartPIE      <= 1'b0;
      tx_ShiftOut      <= 1'b0;
      tx_Busy          <= 1'b0;
      tx_Done          <= 1'b0;
      tx_Error         <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_hdr_pre        <= w_hdr_pre_nxt;
      r_bits_left      <= w_bits_nxt;
      r_wdog           <= w_wdog_nxt;
      p_PreambleLoad   <= (w_state_nxt == S_HDR_LOAD) &&  w_hdr_pre_nxt;
      p_FrameSyncLoad  <= (w_state_nxt == S_HDR_LOAD) && !w_hdr_pre_nxt;
      p_PreambleStart  <= (w_state_nxt == S_HDR_RUN)  &&  w_hdr_pre_nxt;
      p_FrameSyncStart <= (w_state_nxt == S_HDR_RUN)  && !w_hdr_pre_nxt;
      tx_LoadPIE       <= (w_state_nxt == S_BIT_LOAD);
      tx_StartPIE      <= (w_state_nxt == S_BIT_LOAD) || (w_state_nxt == S_BIT_RUN);
      tx_ShiftOut      <= ((w_state_nxt == S_BIT_LOAD) || (w_state_nxt == S_BIT_RUN)) &&
                          w_sreg_nxt[DATA_W-1];
      tx_Busy          <= (w_state_nxt != S_IDLE);
      tx_Done          <= (w_state_nxt == S_FINISH);
      tx_Error         <= w_err_nxt;
    end
  end

  // Command data path carries no reset; it is always loaded before use
  always_ff @(posedge Clk) begin
    r_sreg <= w_sreg_nxt;
  end

endmodule

// File: doc/matrix_txpiectrl.md
Name: matrix_txpiectrl

Overview:
- TX frame sequencer sitting directly upstream of the PIE encoder.
- Accepts a command (up to 64 bits, MSB first) plus a header select. Drives the encoder's preamble or frame-sync generator, then feeds command bits one at a time through the encoder's data-symbol handshake.
- Reports busy, done and watchdog error to the reader MAC.

Parameters:
- DATA_W, 64, command buffer width; bits are sent from bit DATA_W-1 downward.
- CNT_W, 7, width of the bit-count input; must satisfy 2^CNT_W > DATA_W.
- WDOG_W, 20, width of the per-stage watchdog counter.
- WDOG_MAX, 20'hFFFFF, cycles allowed in HDR_RUN or BIT_RUN before an error is declared.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- tx_Start  in  1  single-cycle request; sampled only in IDLE.
- tx_Abort  in  1  level; forces a return to IDLE.
- tx_UsePreamble  in  1  1 = preamble (Query), 0 = frame-sync; sampled with tx_Start.
- tx_BitCount  in  CNT_W  number of command bits to send; sampled with tx_Start.
- tx_Data  in  DATA_W  command bits, MSB-aligned; sampled with tx_Start.
- p_PreambleLoad  out  1  preamble counter load pulse.
- p_PreambleStart  out  1  preamble run enable.
- p_PreambleDone  in  1  last preamble cycle (combinational from the encoder).
- p_FrameSyncLoad  out  1  frame-sync load pulse.
- p_FrameSyncStart  out  1  frame-sync run enable.
- p_FrameSyncDone  in  1  last frame-sync cycle.
- tx_LoadPIE  out  1  data-symbol load pulse.
- tx_StartPIE  out  1  data-symbol run enable.
- tx_ShiftOut  out  1  current command bit.
- tx_ShiftNextBitToPIE  in  1  last cycle of the current data symbol.
- tx_Busy  out  1  high in every state except IDLE.
- tx_Done  out  1  one-cycle pulse on normal completion.
- tx_Error  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered. Every output resets to 0 and the FSM resets to IDLE.
- States: IDLE, HDR_LOAD, HDR_RUN, BIT_LOAD, BIT_RUN, FINISH.
- IDLE:
  - On tx_Start, latch tx_Data into a shift register, tx_UsePreamble into a header-select register, and min(tx_BitCount, DATA_W) into BitsLeft.
  - Go to HDR_LOAD.
  - tx_Start while not in IDLE is ignored.
- HDR_LOAD (1 cycle):
  - Assert p_PreambleLoad if the header-select register is 1, otherwise p_FrameSyncLoad.
  - Next state is HDR_RUN.
- HDR_RUN:
  - Hold the selected *Start high.
  - When the selected *Done is sampled high:
    - if BitsLeft == 0, go to FINISH;
    - otherwise go to BIT_LOAD.
  - *Start stays high through the Done cycle and drops on the following cycle.
- BIT_LOAD (1 cycle):
  - tx_LoadPIE = 1, tx_StartPIE = 1, tx_ShiftOut = sreg[DATA_W-1].
  - Next state is BIT_RUN.
- BIT_RUN:
  - tx_StartPIE = 1 and tx_ShiftOut stays stable (the encoder latches the symbol length on its first cycle).
  - When tx_ShiftNextBitToPIE is sampled high:
    - shift sreg left by one (zero fill) and decrement BitsLeft;
    - if the new BitsLeft is 0, go to FINISH, otherwise go to BIT_LOAD.
- FINISH (1 cycle):
  - Pulse tx_Done; tx_StartPIE = 0.
  - Next state is IDLE.
- Latency: first load pulse one cycle after tx_Start. Gap between consecutive symbols = one BIT_LOAD cycle after the NextBit cycle.
- tx_ShiftNextBitToPIE outside BIT_RUN and *Done outside HDR_RUN are ignored.
- Watchdog:
  - Clears on entry to HDR_RUN or BIT_RUN and counts every cycle spent in those states.
  - Reaching WDOG_MAX pulses tx_Error and returns to IDLE with all strobes low. tx_Done is not pulsed.
- tx_Abort:
  - Has priority over all transitions.
  - Next cycle: state IDLE, all strobes/enables low, tx_Busy 0, no tx_Done, no tx_Error.
  - The shift register is left unchanged.
- tx_BitCount == 0 sends the header only; tx_Done follows one cycle after the header Done.
- tx_BitCount > DATA_W is clamped to DATA_W.
- Asynchronous reset mid-frame: all outputs drop immediately. A new frame may start on the first tx_Start after Reset deasserts.

Test Plan:
- Frame-sync, 4 bits: tx_UsePreamble=0, tx_BitCount=4, tx_Data=64'hA000_0000_0000_0000, encoder lengths Data0=2/Data1=4/PW=1 → p_FrameSyncLoad at cycle 1; four BIT_LOAD pulses with tx_ShiftOut sequence 1,0,1,0; tx_Done one cycle after the 4th NextBit; tx_Busy high from cycle 1 until tx_Done.
- Preamble, 22-bit Query: tx_UsePreamble=1, tx_BitCount=22 → p_PreambleLoad/p_PreambleStart used; no FrameSync strobes ever asserted; exactly 22 tx_LoadPIE pulses.
- Zero-length and clamp cases:
  - tx_BitCount=0 → header only; zero tx_LoadPIE pulses; tx_Done one cycle after the header Done.
  - tx_BitCount=100 → exactly 64 tx_LoadPIE pulses.
- Abort mid-symbol: tx_Abort asserted during bit 3 of 8 → next cycle all outputs 0 and tx_Busy=0; a subsequent tx_Start runs a full, correct frame.
- Watchdog: WDOG_MAX=16, header Done held low → tx_Error pulses after 16 HDR_RUN cycles; FSM back in IDLE; tx_Done never asserted.
- Start while busy plus async reset: a second tx_Start mid-frame is ignored (frame completes with the original data); asserting Reset mid-BIT_RUN zeroes every output immediately.
